// File: rtl/shapool_host_ctrl.sv
// ---------------------------------------------------------------------------
// shapool_host_ctrl
//   Host-side SPI initiator that takes one shapool device through a whole job:
//   hold the device in reset, write the config word on SPI1, write the job word
//   on SPI0, release reset, wait for ready_n, then read the result back on SPI1.
//
// Ports
//   clk_in            system clock (only clock)
//   reset_n_in        synchronous active-low reset
//   start_in          one-cycle job start, ignored while busy
//   cfg_data_in       config word, captured on start
//   job_data_in       job word, captured on start
//   busy_out          high from the cycle after start until DONE
//   done_out          one-cycle pulse at job end
//   result_valid_out  result was read (held until next start)
//   timeout_out       WAIT expired (held until next start)
//   result_out        last result read, MSB first
//   dev_reset_n_out   device reset: low = load, high = run
//   sck0/sdo0/cs0_n   SPI0 master (job)
//   sck1/sdo1/cs1_n   SPI1 master (config write / result read)
//   sdi1_in           SPI1 data from the device
//   ready_n_in        device result-ready, active low, asynchronous
// ---------------------------------------------------------------------------
module shapool_host_ctrl #(
    parameter int CLK_DIV        = 4,
    parameter int CFG_BITS       = 8,
    parameter int JOB_BITS       = 360,
    parameter int RESULT_BITS    = 32,
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   start_in,
    input  logic [CFG_BITS-1:0]    cfg_data_in,
    input  logic [JOB_BITS-1:0]    job_data_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   result_valid_out,
    output logic                   timeout_out,
    output logic [RESULT_BITS-1:0] result_out,
    output logic                   dev_reset_n_out,
    output logic                   sck0_out,
    output logic                   sdo0_out,
    output logic                   cs0_n_out,
    output logic                   sck1_out,
    output logic                   sdo1_out,
    output logic                   cs1_n_out,
    input  logic                   sdi1_in,
    input  logic                   ready_n_in
);

    localparam int MAX_A    = (CFG_BITS > RESULT_BITS) ? CFG_BITS : RESULT_BITS;
    localparam int MAX_BITS = (JOB_BITS > MAX_A) ? JOB_BITS : MAX_A;
    localparam int BIT_W    = (MAX_BITS > 2) ? $clog2(MAX_BITS) : 1;
    localparam int PH_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_CFG, S_JOB, S_RUN, S_WAIT, S_READ, S_DONE
    } state_t;

    // Sub-phase of a shift state: data bits, SCK-low tail with CS still
    // asserted, then CS-high gap before moving on.
    typedef enum logic [1:0] {SEG_BITS, SEG_TAIL, SEG_GAP} seg_t;

    state_t                 state_q, state_d;
    seg_t                   seg_q;
    logic                   half_q;
    logic [PH_W-1:0]        phase_q;
    logic [BIT_W-1:0]       bit_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic [CFG_BITS-1:0]    cfg_sr_q;
    logic [JOB_BITS-1:0]    job_sr_q;
    logic [RESULT_BITS-1:0] res_sr_q;
    logic [RESULT_BITS-1:0] result_q;
    logic                   rvalid_q;
    logic                   timeout_q;
    logic [1:0]             rdy_sync_q;

    logic counting, shifting, last_phase, last_bit;
    logic bit_end, tail_end, gap_end, ready_s, to_term;

    assign counting   = (state_q == S_PRE) || (state_q == S_CFG) ||
                        (state_q == S_JOB) || (state_q == S_READ);
    assign shifting   = (state_q == S_CFG) || (state_q == S_JOB) || (state_q == S_READ);
    assign last_phase = (phase_q == PH_W'(CLK_DIV - 1));
    assign bit_end    = shifting && (seg_q == SEG_BITS) && half_q && last_phase;
    assign tail_end   = shifting && (seg_q == SEG_TAIL) && last_phase;
    assign gap_end    = shifting && (seg_q == SEG_GAP) && last_phase;
    assign ready_s    = ~rdy_sync_q[1];
    assign to_term    = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            S_CFG:   last_bit = (bit_q == BIT_W'(CFG_BITS - 1));
            S_JOB:   last_bit = (bit_q == BIT_W'(JOB_BITS - 1));
            S_READ:  last_bit = (bit_q == BIT_W'(RESULT_BITS - 1));
            default: last_bit = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_in)   state_d = S_PRE;
            S_PRE:  if (last_phase) state_d = S_CFG;
            S_CFG:  if (gap_end)    state_d = S_JOB;
            S_JOB:  if (gap_end)    state_d = S_RUN;
            S_RUN:                  state_d = S_WAIT;
            // A ready seen on the terminal count still wins over the timeout.
            S_WAIT: begin
                if (ready_s)      state_d = S_READ;
                else if (to_term) state_d = S_DONE;
            end
            // No CS gap after the read: DONE/IDLE already keep CS high.
            S_READ: if (tail_end)   state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Bit engine, shift registers, timeout counter and sticky status
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            seg_q      <= SEG_BITS;
            half_q     <= 1'b0;
            phase_q    <= '0;
            bit_q      <= '0;
            to_cnt_q   <= '0;
            cfg_sr_q   <= '0;
            job_sr_q   <= '0;
            res_sr_q   <= '0;
            result_q   <= '0;
            rvalid_q   <= 1'b0;
            timeout_q  <= 1'b0;
            rdy_sync_q <= 2'b11;
        end else begin
            rdy_sync_q <= {rdy_sync_q[0], ready_n_in};

            // Engine restarts cleanly on every state entry.
            if (!counting || (state_d != state_q)) begin
                seg_q   <= SEG_BITS;
                half_q  <= 1'b0;
                phase_q <= '0;
                bit_q   <= '0;
            end else begin
                phase_q <= last_phase ? '0 : phase_q + 1'b1;
                if (last_phase && shifting) begin
                    case (seg_q)
                        SEG_BITS: begin
                            half_q <= ~half_q;
                            if (half_q) begin
                                if (last_bit) begin
                                    seg_q <= SEG_TAIL;
                                    bit_q <= '0;
                                end else begin
                                    bit_q <= bit_q + 1'b1;
                                end
                            end
                        end
                        SEG_TAIL: seg_q <= SEG_GAP;
                        default:  seg_q <= seg_q;
                    endcase
                end
            end

            if ((state_q == S_IDLE) && start_in) begin
                cfg_sr_q  <= cfg_data_in;
                job_sr_q  <= job_data_in;
                rvalid_q  <= 1'b0;
                timeout_q <= 1'b0;
            end

            // Data advances at the end of each bit so the next MSB appears
            // in the first low cycle of the following bit.
            if (bit_end) begin
                case (state_q)
                    S_CFG:   cfg_sr_q <= {cfg_sr_q[CFG_BITS-2:0], 1'b0};
                    S_JOB:   job_sr_q <= {job_sr_q[JOB_BITS-2:0], 1'b0};
                    S_READ:  res_sr_q <= {res_sr_q[RESULT_BITS-2:0], sdi1_in};
                    default: ;
                endcase
            end

            // Result only becomes visible once the full word is in.
            if ((state_q == S_READ) && tail_end) begin
                result_q <= res_sr_q;
                rvalid_q <= 1'b1;
            end

            if (state_q == S_RUN) begin
                to_cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                to_cnt_q <= to_cnt_q + 1'b1;
                if (!ready_s && to_term) timeout_q <= 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        busy_out         = (state_q != S_IDLE) && (state_q != S_DONE);
        done_out         = (state_q == S_DONE);
        result_valid_out = rvalid_q;
        timeout_out      = timeout_q;
        result_out       = result_q;
        dev_reset_n_out  = !((state_q == S_PRE) || (state_q == S_CFG) || (state_q == S_JOB));
        cs0_n_out        = !((state_q == S_JOB) && (seg_q != SEG_GAP));
        cs1_n_out        = !(((state_q == S_CFG) || (state_q == S_READ)) && (seg_q != SEG_GAP));
        sck0_out         = (state_q == S_JOB) && (seg_q == SEG_BITS) && half_q;
        sck1_out         = ((state_q == S_CFG) || (state_q == S_READ)) &&
                           (seg_q == SEG_BITS) && half_q;
        sdo0_out         = (state_q == S_JOB) && (seg_q == SEG_BITS) && job_sr_q[JOB_BITS-1];
        sdo1_out         = (state_q == S_CFG) && (seg_q == SEG_BITS) && cfg_sr_q[CFG_BITS-1];
    end

endmodule

// File: tb/tb_shapool_host_ctrl.sv
module tb_shapool_host_ctrl;

    localparam int CLK_DIV = 4;
    localparam int TO_A    = 1024;
    localparam int TO_B    = 64;
    localparam int LIMIT   = 6000;

    logic        clk = 1'b0;
    logic [1:0]  rst_n, start, sdi1, ready_n;
    logic [7:0]  cfg_d [2];
    logic [359:0] job_d [2];
    logic [1:0]  busy, done, rv, to, devr, sck0, sdo0, cs0, sck1, sdo1, cs1;
    logic [31:0] res [2];
    logic [31:0] exp_res [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shapool_host_ctrl #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TO_A)) dut_a (
        .clk_in(clk), .reset_n_in(rst_n[0]), .start_in(start[0]),
        .cfg_data_in(cfg_d[0]), .job_data_in(job_d[0]),
        .busy_out(busy[0]), .done_out(done[0]), .result_valid_out(rv[0]),
        .timeout_out(to[0]), .result_out(res[0]), .dev_reset_n_out(devr[0]),
        .sck0_out(sck0[0]), .sdo0_out(sdo0[0]), .cs0_n_out(cs0[0]),
        .sck1_out(sck1[0]), .sdo1_out(sdo1[0]), .cs1_n_out(cs1[0]),
        .sdi1_in(sdi1[0]), .ready_n_in(ready_n[0])
    );

    shapool_host_ctrl #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TO_B)) dut_b (
        .clk_in(clk), .reset_n_in(rst_n[1]), .start_in(start[1]),
        .cfg_data_in(cfg_d[1]), .job_data_in(job_d[1]),
        .busy_out(busy[1]), .done_out(done[1]), .result_valid_out(rv[1]),
        .timeout_out(to[1]), .result_out(res[1]), .dev_reset_n_out(devr[1]),
        .sck0_out(sck0[1]), .sdo0_out(sdo0[1]), .cs0_n_out(cs0[1]),
        .sck1_out(sck1[1]), .sdo1_out(sdo1[1]), .cs1_n_out(cs1[1]),
        .sdi1_in(sdi1[1]), .ready_n_in(ready_n[1])
    );

    task automatic check(input string tag, input logic [359:0] obs, input logic [359:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [359:0] rand_job();
        logic [359:0] j;
        j = '0;
        for (int i = 0; i < 12; i++) j = {j[327:0], $urandom()};
        return j;
    endfunction

    // Runs one job on instance u while acting as the device's SPI slaves.
    // rdy_dly: cycles after the RUN cycle at which ready_n_in is pulled low
    // (-1 = never). With a 2-flop synchroniser the device-side ready is seen
    // rdy_dly+2 cycles after RUN, and the last WAIT cycle is RUN+TIMEOUT, so a
    // read happens exactly when rdy_dly <= TIMEOUT-2.
    task automatic run_job(input int u, input logic [7:0] cfg, input logic [359:0] job,
                           input int rdy_dly, input logic [31:0] dres,
                           input bit disturb, input bit abort);
        int cyc, run_cyc, cfg_n, job_n, rd_idx, cs1_cfg_low, overlap, devr_bad, sdo_rd_bad;
        int to_cyc;
        logic [7:0]   cfg_rx;
        logic [359:0] job_rx;
        logic p_sck0, p_sck1, p_cs1, p_devr;
        bit exp_to, aborted, extra, dist_done;

        to_cyc  = (u == 0) ? TO_A : TO_B;
        exp_to  = (rdy_dly < 0) || (rdy_dly > to_cyc - 2);
        cyc = 0; run_cyc = -1; cfg_n = 0; job_n = 0; rd_idx = 32;
        cs1_cfg_low = 0; overlap = 0; devr_bad = 0; sdo_rd_bad = 0;
        cfg_rx = '0; job_rx = '0; aborted = 0; extra = 0; dist_done = 0;
        ready_n[u] = 1'b1; sdi1[u] = 1'b0;

        cfg_d[u] = cfg; job_d[u] = job; start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        check("busy_after_start", busy[u], 1'b1);
        check("rvalid_cleared", rv[u], 1'b0);
        check("timeout_cleared", to[u], 1'b0);
        check("dev_reset_low", devr[u], 1'b0);
        p_sck0 = sck0[u]; p_sck1 = sck1[u]; p_cs1 = cs1[u]; p_devr = devr[u];

        while (done[u] !== 1'b1 && cyc < LIMIT && !aborted) begin
            @(posedge clk); #1;
            cyc++;
            if (extra) begin start[u] = 1'b0; extra = 0; end
            if (!cs0[u] && !cs1[u]) overlap++;
            if (!cs1[u] && !devr[u]) cs1_cfg_low++;
            if (!cs0[u] && devr[u]) devr_bad++;
            if (sck1[u] && !p_sck1 && !cs1[u] && !devr[u]) begin
                cfg_rx = {cfg_rx[6:0], sdo1[u]};
                cfg_n++;
            end
            if (sck0[u] && !p_sck0 && !cs0[u]) begin
                job_rx = {job_rx[358:0], sdo0[u]};
                job_n++;
            end
            if (devr[u] && !p_devr && run_cyc < 0) run_cyc = cyc;
            if (devr[u] && !cs1[u]) begin
                if (p_cs1) rd_idx = 0;
                else if (p_sck1 && !sck1[u]) rd_idx++;
                if (sdo1[u]) sdo_rd_bad++;
            end
            sdi1[u] = (rd_idx < 32) ? dres[31 - rd_idx] : 1'b0;
            if (run_cyc >= 0 && rdy_dly >= 0 && cyc == run_cyc + rdy_dly) ready_n[u] = 1'b0;
            if (disturb && !dist_done && job_n == 50) begin
                start[u] = 1'b1; cfg_d[u] = ~cfg; job_d[u] = ~job;
                extra = 1; dist_done = 1;
            end
            if (abort && job_n == 100) aborted = 1;
            p_sck0 = sck0[u]; p_sck1 = sck1[u]; p_cs1 = cs1[u]; p_devr = devr[u];
        end

        if (aborted) begin
            rst_n[u] = 1'b0;
            @(posedge clk); #1;
            check("abort_cs0_high", cs0[u], 1'b1);
            check("abort_cs1_high", cs1[u], 1'b1);
            check("abort_busy_low", busy[u], 1'b0);
            check("abort_sck0_low", sck0[u], 1'b0);
            check("abort_devr_high", devr[u], 1'b1);
            check("abort_result_zero", res[u], 32'h0);
            rst_n[u] = 1'b1;
            exp_res[u] = '0;
        end else begin
            check("finished_in_budget", done[u], 1'b1);
            check("busy_low_at_done", busy[u], 1'b0);
            check("cfg_bit_count", cfg_n, 8);
            check("cfg_word", cfg_rx, cfg);
            check("cs1_cfg_low_cycles", cs1_cfg_low, 8 * 2 * CLK_DIV + CLK_DIV);
            check("job_bit_count", job_n, 360);
            check("job_word", job_rx, job);
            check("cs_overlap", overlap, 0);
            check("devr_high_in_job", devr_bad, 0);
            if (exp_to) begin
                check("timeout_flag", to[u], 1'b1);
                check("rvalid_on_timeout", rv[u], 1'b0);
                check("result_unchanged", res[u], exp_res[u]);
                check("timeout_latency", cyc - run_cyc, to_cyc + 1);
            end else begin
                check("timeout_flag", to[u], 1'b0);
                check("rvalid", rv[u], 1'b1);
                check("result", res[u], dres);
                check("read_bits", rd_idx, 32);
                check("sdo1_zero_in_read", sdo_rd_bad, 0);
                exp_res[u] = dres;
            end
            @(posedge clk); #1;
            check("done_one_cycle", done[u], 1'b0);
            check("idle_not_busy", busy[u], 1'b0);
        end
        ready_n[u] = 1'b1;
        sdi1[u]    = 1'b0;
    endtask

    initial begin
        rst_n = 2'b00; start = 2'b00; sdi1 = 2'b00; ready_n = 2'b11;
        cfg_d[0] = '0; cfg_d[1] = '0; job_d[0] = '0; job_d[1] = '0;
        exp_res[0] = '0; exp_res[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_busy", busy[u], 1'b0);
            check("rst_done", done[u], 1'b0);
            check("rst_rvalid", rv[u], 1'b0);
            check("rst_timeout", to[u], 1'b0);
            check("rst_result", res[u], 32'h0);
            check("rst_devr", devr[u], 1'b1);
            check("rst_cs", {cs0[u], cs1[u]}, 2'b11);
            check("rst_sck_sdo", {sck0[u], sck1[u], sdo0[u], sdo1[u]}, 4'b0000);
        end
        rst_n = 2'b11;
        @(posedge clk); #1;

        // Directed job: known config/job/result
        run_job(0, 8'hA5,
                360'hdc6a3b8d_0c69421a_cb1a5434_e536f7d5_c3c1b9e4_4cbb9b8f_95f0172e_fc48d2df_dc141787_358b0553_535f0119,
                100, 32'h1234_abcd, 1'b0, 1'b0);

        // Random job with a second start pulse during the job shift
        run_job(0, 8'($urandom()), rand_job(), int'($urandom_range(3, 300)), $urandom(), 1'b1, 1'b0);

        // Short-timeout instance: good read, timeout, tie, one-past-tie
        run_job(1, 8'($urandom()), rand_job(), 10, $urandom(), 1'b0, 1'b0);
        run_job(1, 8'($urandom()), rand_job(), -1, $urandom(), 1'b0, 1'b0);
        run_job(1, 8'($urandom()), rand_job(), TO_B - 2, $urandom(), 1'b0, 1'b0);
        run_job(1, 8'($urandom()), rand_job(), TO_B - 1, $urandom(), 1'b0, 1'b0);

        // Reset during job bit 100, then a fresh job
        run_job(0, 8'($urandom()), rand_job(), 50, $urandom(), 1'b0, 1'b1);
        @(posedge clk); #1;
        run_job(0, 8'($urandom()), rand_job(), int'($urandom_range(0, 200)), $urandom(), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
